t5_csru: RTL and testbench

Multi-hart machine-mode CSR and trap unit for the t5 barrel pipeline. It holds one register bank per hardware thread and performs CSR read/modify/write for the hart issuing in the execute stage. It sequences trap entry and `mret`, producing a redirect vector for fetch. It also maintains cycle/instret counters and per-hart timer-interrupt pending state.

---
 rtl/t5_csr_pkg.sv | 55 +++++
 rtl/t5_csr_if.sv | 36 +++
 rtl/t5_csr_bank.sv | 59 +++++
 rtl/t5_csru.sv | 142 ++++++++++++++
 tb/tb_t5_csru.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/t5_csr_pkg.sv
// Shared definitions for the t5 CSR/trap unit: CSR addresses, op encodings,
// cause codes and the per-hart register bank layout.
package t5_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;
    localparam logic [3:0] CAUSE_M_TIMER = 4'd7;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLR   = 2'b11
    } csr_op_e;

    typedef struct packed {
        logic        mie;
        logic        mpie;
        logic        mtie;
        logic        mtip;
        logic [31:0] mtvec;
        logic [29:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
        logic [31:0] mscratch;
    } bank_t;

    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] rold,
                                              input logic [31:0] wdat);
        case (op)
            OP_WRITE: return wdat;
            OP_SET:   return rold | wdat;
            OP_CLR:   return rold & ~wdat;
            default:  return rold;
        endcase
    endfunction

endpackage

// File: rtl/t5_csr_if.sv
// Execute-stage CSR/trap bus between the t5 pipeline (master) and t5_csru (slave).
interface t5_csr_if #(
    parameter int XLEN  = 32,
    parameter int HARTS = 4,
    parameter int HW    = (HARTS > 1) ? $clog2(HARTS) : 1
);
    logic              sena;
    logic [HW-1:0]     hart;
    logic              csr_we;
    logic [1:0]        csr_op;
    logic [11:0]       csr_adr;
    logic [XLEN-1:0]   csr_wdat;
    logic [XLEN-1:0]   csr_rdat;
    logic              trap;
    logic [4:0]        trap_cause;
    logic [XLEN-3:0]   trap_epc;
    logic [XLEN-1:0]   trap_val;
    logic              mret;
    logic              retire;
    logic [HARTS-1:0]  irq_timer;
    logic [XLEN-3:0]   vec_pc;
    logic              vec_vld;
    logic [HARTS-1:0]  irq_pend;

    modport master (
        output sena, hart, csr_we, csr_op, csr_adr, csr_wdat, trap, trap_cause,
               trap_epc, trap_val, mret, retire, irq_timer,
        input  csr_rdat, vec_pc, vec_vld, irq_pend
    );

    modport slave (
        input  sena, hart, csr_we, csr_op, csr_adr, csr_wdat, trap, trap_cause,
               trap_epc, trap_val, mret, retire, irq_timer,
        output csr_rdat, vec_pc, vec_vld, irq_pend
    );
endinterface

// File: rtl/t5_csr_bank.sv
// One hart's machine-mode CSR bank; trap entry beats mret, which beats a CSR write.
module t5_csr_bank
    import t5_csr_pkg::*;
(
    input  logic        sclk,
    input  logic        srst,
    input  logic        ena_i,
    input  logic        sel_i,
    input  logic        we_i,
    input  logic [11:0] adr_i,
    input  logic [31:0] wval_i,
    input  logic        trap_i,
    input  logic [4:0]  cause_i,
    input  logic [29:0] epc_i,
    input  logic [31:0] tval_i,
    input  logic        mret_i,
    input  logic        mtip_i,
    output bank_t       bank_o
);

    bank_t bank_q, bank_d;

    always_comb begin
        bank_d      = bank_q;
        bank_d.mtip = mtip_i;
        if (sel_i && trap_i) begin
            bank_d.mepc   = epc_i;
            bank_d.mcause = {cause_i[4], 27'd0, cause_i[3:0]};
            bank_d.mtval  = tval_i;
            bank_d.mpie   = bank_q.mie;
            bank_d.mie    = 1'b0;
        end else if (sel_i && mret_i) begin
            bank_d.mie  = bank_q.mpie;
            bank_d.mpie = 1'b1;
        end else if (sel_i && we_i) begin
            case (adr_i)
                CSR_MSTATUS: begin
                    bank_d.mie  = wval_i[3];
                    bank_d.mpie = wval_i[7];
                end
                CSR_MIE:      bank_d.mtie     = wval_i[7];
                CSR_MTVEC:    bank_d.mtvec    = wval_i;
                CSR_MSCRATCH: bank_d.mscratch = wval_i;
                CSR_MEPC:     bank_d.mepc     = wval_i[31:2];
                CSR_MCAUSE:   bank_d.mcause   = wval_i;
                CSR_MTVAL:    bank_d.mtval    = wval_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (srst)       bank_q <= '0;
        else if (ena_i) bank_q <= bank_d;
    end

    assign bank_o = bank_q;

endmodule

// File: rtl/t5_csru.sv
// Multi-hart M-mode CSR and trap unit: read mux, counters, redirect and irq outputs.
// Optional counters (mcycle, per-hart minstret) are built when T5_COUNTERS_EN is defined.
module t5_csru
    import t5_csr_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int HARTS = 4
) (
    input logic   sclk,
    input logic   srst,
    t5_csr_if.slave bus
);

    localparam int HW = (HARTS > 1) ? $clog2(HARTS) : 1;

    bank_t            banks [HARTS];
    bank_t            cur;
    logic [XLEN-1:0]  rold, wval;
    logic             commit;
    logic [XLEN-1:0]  rdat_q;
    logic [XLEN-3:0]  vec_pc_q, trap_vec;
    logic             vec_vld_q;
    logic [HARTS-1:0] pend_q, pend_d;

    // A trap or mret on the issuing hart swallows that cycle's CSR write.
    assign commit = bus.csr_we && (bus.csr_op != OP_READ) && !bus.trap && !bus.mret;
    assign wval   = csr_apply(csr_op_e'(bus.csr_op), rold, bus.csr_wdat);

    for (genvar g = 0; g < HARTS; g++) begin : g_bank
        t5_csr_bank u_bank (
            .sclk    (sclk),
            .srst    (srst),
            .ena_i   (bus.sena),
            .sel_i   (bus.hart == HW'(g)),
            .we_i    (commit),
            .adr_i   (bus.csr_adr),
            .wval_i  (wval),
            .trap_i  (bus.trap),
            .cause_i (bus.trap_cause),
            .epc_i   (bus.trap_epc),
            .tval_i  (bus.trap_val),
            .mret_i  (bus.mret),
            .mtip_i  (bus.irq_timer[g]),
            .bank_o  (banks[g])
        );
        assign pend_d[g] = banks[g].mtip & banks[g].mtie & banks[g].mie;
    end

    always_comb begin
        cur = '0;
        for (int h = 0; h < HARTS; h++)
            if (bus.hart == HW'(h)) cur = banks[h];
    end

`ifdef T5_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d, cur_instret;
    logic [63:0] minstret_q [HARTS];
    logic [63:0] minstret_d [HARTS];

    // A software write to either half replaces the whole cycle's increment.
    always_comb begin
        mcycle_d = mcycle_q + 64'd1;
        if (commit && bus.csr_adr == CSR_MCYCLE)       mcycle_d = {mcycle_q[63:32], wval};
        else if (commit && bus.csr_adr == CSR_MCYCLEH) mcycle_d = {wval, mcycle_q[31:0]};
        cur_instret = '0;
        for (int h = 0; h < HARTS; h++) begin
            minstret_d[h] = minstret_q[h];
            if (bus.hart == HW'(h)) begin
                cur_instret = minstret_q[h];
                if (commit && bus.csr_adr == CSR_MINSTRET)
                    minstret_d[h] = {minstret_q[h][63:32], wval};
                else if (commit && bus.csr_adr == CSR_MINSTRETH)
                    minstret_d[h] = {wval, minstret_q[h][31:0]};
                else if (bus.retire)
                    minstret_d[h] = minstret_q[h] + 64'd1;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            mcycle_q <= '0;
            for (int h = 0; h < HARTS; h++) minstret_q[h] <= '0;
        end else if (bus.sena) begin
            mcycle_q <= mcycle_d;
            for (int h = 0; h < HARTS; h++) minstret_q[h] <= minstret_d[h];
        end
    end
`else
    logic unused_retire;
    assign unused_retire = bus.retire;
`endif

    always_comb begin
        rold = '0;
        case (bus.csr_adr)
            CSR_MSTATUS:   rold = {19'd0, 2'b11, 3'd0, cur.mpie, 3'd0, cur.mie, 3'd0};
            CSR_MISA:      rold = MISA_VAL;
            CSR_MIE:       rold = {24'd0, cur.mtie, 7'd0};
            CSR_MIP:       rold = {24'd0, cur.mtip, 7'd0};
            CSR_MTVEC:     rold = cur.mtvec;
            CSR_MSCRATCH:  rold = cur.mscratch;
            CSR_MEPC:      rold = {cur.mepc, 2'b00};
            CSR_MCAUSE:    rold = cur.mcause;
            CSR_MTVAL:     rold = cur.mtval;
            CSR_MHARTID:   rold = XLEN'(bus.hart);
`ifdef T5_COUNTERS_EN
            CSR_MCYCLE:    rold = mcycle_q[31:0];
            CSR_MCYCLEH:   rold = mcycle_q[63:32];
            CSR_MINSTRET:  rold = cur_instret[31:0];
            CSR_MINSTRETH: rold = cur_instret[63:32];
`endif
            default:       rold = '0;
        endcase
    end

    // Vectored mode offsets only interrupts; exceptions always go to the base.
    assign trap_vec = (cur.mtvec[0] && bus.trap_cause[4])
                    ? cur.mtvec[31:2] + 30'(bus.trap_cause[3:0])
                    : cur.mtvec[31:2];

    always_ff @(posedge sclk) begin
        if (srst) begin
            rdat_q    <= '0;
            vec_pc_q  <= '0;
            vec_vld_q <= 1'b0;
            pend_q    <= '0;
        end else if (bus.sena) begin
            rdat_q    <= rold;
            vec_vld_q <= bus.trap | bus.mret;
            pend_q    <= pend_d;
            if (bus.trap)      vec_pc_q <= trap_vec;
            else if (bus.mret) vec_pc_q <= cur.mepc;
        end
    end

    assign bus.csr_rdat = rdat_q;
    assign bus.vec_pc   = vec_pc_q;
    assign bus.vec_vld  = vec_vld_q;
    assign bus.irq_pend = pend_q;

endmodule

// File: tb/tb_t5_csru.sv
// Randomized scoreboard bench for t5_csru against an architectural CSR model.
module tb_t5_csru;
    import t5_csr_pkg::*;

    logic sclk = 1'b0;
    logic srst = 1'b1;
    always #5 sclk = ~sclk;

    t5_csr_if #(.XLEN(32), .HARTS(4)) bus ();
    t5_csru #(.XLEN(32), .HARTS(4)) dut (.sclk(sclk), .srst(srst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Architectural state per hart
    bit          m_mie [4], m_mpie [4], m_mtie [4], m_mtip [4];
    logic [31:0] m_mtvec [4], m_mepc [4], m_mcause [4], m_mtval [4], m_mscratch [4];
    logic [63:0] m_minstret [4];
    logic [63:0] m_mcycle;
    logic [3:0]  tmr_lvl = 4'd0;

    logic [31:0] q_rd [$];
    logic [29:0] q_vec [$];
    logic [3:0]  q_pend [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int h = 0; h < 4; h++) begin
            m_mie[h] = 0; m_mpie[h] = 0; m_mtie[h] = 0; m_mtip[h] = 0;
            m_mtvec[h] = 0; m_mepc[h] = 0; m_mcause[h] = 0; m_mtval[h] = 0;
            m_mscratch[h] = 0; m_minstret[h] = 0;
        end
        m_mcycle = 0;
    endtask

    function automatic logic [31:0] mread(input int h, input logic [11:0] a);
        case (a)
            CSR_MSTATUS:  return 32'h1800 | (32'(m_mie[h]) << 3) | (32'(m_mpie[h]) << 7);
            CSR_MISA:     return 32'h4000_0100;
            CSR_MIE:      return 32'(m_mtie[h]) << 7;
            CSR_MIP:      return 32'(m_mtip[h]) << 7;
            CSR_MTVEC:    return m_mtvec[h];
            CSR_MSCRATCH: return m_mscratch[h];
            CSR_MEPC:     return m_mepc[h];
            CSR_MCAUSE:   return m_mcause[h];
            CSR_MTVAL:    return m_mtval[h];
            CSR_MHARTID:  return 32'(h);
`ifdef T5_COUNTERS_EN
            CSR_MCYCLE:    return m_mcycle[31:0];
            CSR_MCYCLEH:   return m_mcycle[63:32];
            CSR_MINSTRET:  return m_minstret[h][31:0];
            CSR_MINSTRETH: return m_minstret[h][63:32];
`endif
            default:      return 32'd0;
        endcase
    endfunction

    // Drive one cycle, predict its responses, then advance the model past the edge.
    task automatic step(input int h, input bit we, input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input bit tr, input logic [4:0] cause,
                        input logic [29:0] epc, input logic [31:0] tval, input bit mr,
                        input bit ret, input logic [3:0] tmr, input bit en);
        logic [31:0] rold, nv;
        logic [29:0] vec;
        logic [3:0]  pend;
        bit          commit, cyc_inc, ins_inc;
        bus.hart = h[1:0]; bus.csr_we = we; bus.csr_op = op; bus.csr_adr = a;
        bus.csr_wdat = wd; bus.trap = tr; bus.trap_cause = cause; bus.trap_epc = epc;
        bus.trap_val = tval; bus.mret = mr; bus.retire = ret; bus.irq_timer = tmr;
        bus.sena = en;
        if (en) begin
            rold = mread(h, a);
            case (op)
                2'b01:   nv = wd;
                2'b10:   nv = rold | wd;
                2'b11:   nv = rold & ~wd;
                default: nv = rold;
            endcase
            commit = we && op != 2'b00 && !tr && !mr;
            if (we) q_rd.push_back(rold);
            if (tr) begin
                vec = m_mtvec[h][31:2];
                if (m_mtvec[h][0] && cause[4]) vec = vec + 30'(cause[3:0]);
                q_vec.push_back(vec);
            end else if (mr) q_vec.push_back(m_mepc[h][31:2]);
            for (int g = 0; g < 4; g++) pend[g] = m_mtip[g] & m_mtie[g] & m_mie[g];
            q_pend.push_back(pend);
            cyc_inc = 1; ins_inc = ret;
            if (commit) begin
                case (a)
                    CSR_MCYCLE:    begin m_mcycle[31:0] = nv; cyc_inc = 0; end
                    CSR_MCYCLEH:   begin m_mcycle[63:32] = nv; cyc_inc = 0; end
                    CSR_MINSTRET:  begin m_minstret[h][31:0] = nv; ins_inc = 0; end
                    CSR_MINSTRETH: begin m_minstret[h][63:32] = nv; ins_inc = 0; end
                    default: ;
                endcase
            end
            if (cyc_inc) m_mcycle = m_mcycle + 1;
            if (ins_inc) m_minstret[h] = m_minstret[h] + 1;
            for (int g = 0; g < 4; g++) m_mtip[g] = tmr[g];
            if (tr) begin
                m_mepc[h] = {epc, 2'b00};
                m_mcause[h] = {cause[4], 27'd0, cause[3:0]};
                m_mtval[h] = tval;
                m_mpie[h] = m_mie[h];
                m_mie[h] = 0;
            end else if (mr) begin
                m_mie[h] = m_mpie[h];
                m_mpie[h] = 1;
            end else if (commit) begin
                case (a)
                    CSR_MSTATUS:  begin m_mie[h] = nv[3]; m_mpie[h] = nv[7]; end
                    CSR_MIE:      m_mtie[h] = nv[7];
                    CSR_MTVEC:    m_mtvec[h] = nv;
                    CSR_MSCRATCH: m_mscratch[h] = nv;
                    CSR_MEPC:     m_mepc[h] = {nv[31:2], 2'b00};
                    CSR_MCAUSE:   m_mcause[h] = nv;
                    CSR_MTVAL:    m_mtval[h] = nv;
                    default: ;
                endcase
            end
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic csr(input int h, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        step(h, 1, op, a, wd, 0, 5'd0, 30'd0, 32'd0, 0, 0, tmr_lvl, 1);
    endtask

    task automatic idle(input bit ret = 0, input int h = 0);
        step(h, 0, 2'b00, 12'h000, 32'd0, 0, 5'd0, 30'd0, 32'd0, 0, ret, tmr_lvl, 1);
    endtask

    // Monitor: pops expectations whenever an enabled edge produced outputs.
    bit mon_en, mon_rd, mon_rst, have_prev;
    logic        prev_vld;
    logic [31:0] prev_rdat;
    always @(posedge sclk) begin
        mon_rst <= srst;
        mon_en  <= !srst && bus.sena;
        mon_rd  <= !srst && bus.sena && bus.csr_we;
    end

    always @(negedge sclk) begin
        if (mon_en) begin
            if (q_pend.size() == 0) check("pend_underflow", 1, 0);
            else check("irq_pend", bus.irq_pend, q_pend.pop_front());
            if (mon_rd) begin
                if (q_rd.size() == 0) check("rd_underflow", 1, 0);
                else check("csr_rdat", bus.csr_rdat, q_rd.pop_front());
            end
            if (bus.vec_vld) begin
                if (q_vec.size() == 0) check("vec_vld_spurious", 1, 0);
                else check("vec_pc", bus.vec_pc, q_vec.pop_front());
            end
            have_prev = 1;
        end else if (!mon_rst && have_prev) begin
            check("hold_vec_vld", bus.vec_vld, prev_vld);
            check("hold_rdat", bus.csr_rdat, prev_rdat);
        end
        prev_vld  = bus.vec_vld;
        prev_rdat = bus.csr_rdat;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.sena = 1; bus.hart = 0; bus.csr_we = 0; bus.csr_op = 0; bus.csr_adr = 0;
        bus.csr_wdat = 0; bus.trap = 0; bus.trap_cause = 0; bus.trap_epc = 0;
        bus.trap_val = 0; bus.mret = 0; bus.retire = 0; bus.irq_timer = 0;
        model_reset();
        repeat (3) @(posedge sclk);
        #1;
        check("rst_rdat", bus.csr_rdat, 0);
        check("rst_vec_pc", bus.vec_pc, 0);
        check("rst_vec_vld", bus.vec_vld, 0);
        check("rst_irq_pend", bus.irq_pend, 0);
        srst = 0;

        csr(0, OP_READ, CSR_MTVEC, 0);
        csr(0, OP_READ, CSR_MSTATUS, 0);
        csr(0, OP_READ, CSR_MISA, 0);

        // Vectored interrupt on hart 2
        csr(2, OP_WRITE, CSR_MTVEC, 32'h8000_0101);
        step(2, 0, 0, 0, 0, 1, 5'h17, 30'h100, 32'h77, 0, 0, tmr_lvl, 1);
        csr(2, OP_READ, CSR_MCAUSE, 0);
        csr(1, OP_READ, CSR_MCAUSE, 0);

        // mstatus round trip through trap and mret on hart 1
        csr(1, OP_SET, CSR_MSTATUS, 32'h88);
        csr(1, OP_READ, CSR_MSTATUS, 0);
        step(1, 0, 0, 0, 0, 1, 5'h0B, 30'h2345, 32'h0, 0, 0, tmr_lvl, 1);
        csr(1, OP_READ, CSR_MSTATUS, 0);
        step(1, 0, 0, 0, 0, 0, 5'd0, 30'd0, 32'd0, 1, 0, tmr_lvl, 1);
        csr(1, OP_READ, CSR_MSTATUS, 0);

        // Trap beats a same-cycle write; rdat still returns the old value
        csr(3, OP_WRITE, CSR_MSCRATCH, 32'h11);
        step(3, 1, OP_WRITE, CSR_MSCRATCH, 32'h55, 1, 5'h02, 30'h3, 32'hDEAD, 0, 0, tmr_lvl, 1);
        csr(3, OP_READ, CSR_MSCRATCH, 0);
        csr(3, OP_READ, CSR_MTVAL, 0);

        // Timer interrupt pending on hart 0
        csr(0, OP_SET, CSR_MIE, 32'h80);
        csr(0, OP_SET, CSR_MSTATUS, 32'h8);
        tmr_lvl = 4'b0001;
        idle(); idle(); idle();
        csr(0, OP_READ, CSR_MIP, 0);
        csr(0, OP_CLR, CSR_MSTATUS, 32'h8);
        idle(); idle();
        tmr_lvl = 4'b0000;

        // Counters wrap and retire accounting
        csr(0, OP_WRITE, CSR_MCYCLE, 32'hFFFF_FFFF);
        csr(0, OP_WRITE, CSR_MCYCLEH, 32'hFFFF_FFFF);
        idle(); idle();
        csr(0, OP_READ, CSR_MCYCLE, 0);
        csr(0, OP_READ, CSR_MCYCLEH, 0);
        idle(1, 1); idle(1, 1); idle(1, 1);
        csr(1, OP_READ, CSR_MINSTRET, 0);
        csr(0, OP_READ, CSR_MINSTRET, 0);
        csr(2, OP_READ, CSR_MHARTID, 0);

        // Strobe held across disabled cycles
        step(0, 0, 0, 0, 0, 1, 5'h03, 30'h44, 32'h0, 0, 0, tmr_lvl, 1);
        step(1, 1, OP_WRITE, CSR_MSCRATCH, 32'h99, 1, 5'h1, 30'h5, 32'h1, 0, 1, 4'hF, 0);
        step(2, 1, OP_WRITE, CSR_MTVEC, 32'h99, 0, 5'h0, 30'h0, 32'h0, 1, 1, 4'hF, 0);
        idle();
        csr(1, OP_READ, CSR_MSCRATCH, 0);

        for (int i = 0; i < 500; i++) begin
            logic [11:0] adrs [16];
            adrs = '{CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
                     CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET,
                     CSR_MINSTRETH, CSR_MHARTID, 12'h7C0, 12'h000};
            if ($urandom_range(0, 7) == 0) tmr_lvl = 4'($urandom);
            step($urandom_range(0, 3), 1'($urandom), 2'($urandom), adrs[$urandom_range(0, 15)],
                 ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255)),
                 $urandom_range(0, 9) == 0, 5'($urandom), 30'($urandom), 32'($urandom),
                 $urandom_range(0, 9) == 0, 1'($urandom), tmr_lvl, $urandom_range(0, 7) != 0);
        end
        idle();

        // Reset during a trap cancels the strobe
        bus.hart = 2; bus.trap = 1; bus.trap_cause = 5'h05; bus.sena = 1; bus.csr_we = 0;
        srst = 1;
        @(posedge sclk);
        #1;
        check("rst_trap_vld", bus.vec_vld, 0);
        check("rst_trap_vpc", bus.vec_pc, 0);
        srst = 0;
        bus.trap = 0;
        model_reset();
        tmr_lvl = 4'd0;
        csr(2, OP_READ, CSR_MTVEC, 0);
        csr(1, OP_READ, CSR_MSTATUS, 0);
        idle();
        @(negedge sclk);
        #1;
        check("vec_queue_drained", q_vec.size(), 0);
        check("rd_queue_drained", q_rd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
